// File: rtl/agc_lock_detect_pkg.sv
// ---------------------------------------------------------------------------
// agc_lock_detect_pkg: shared widths, state encoding and power-target defaults
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package agc_lock_detect_pkg;

  localparam int SAMPLE_W = 8;
  localparam int ABS2_W   = 17;

  // The AGC loop's power-target setting uses these same values.
  localparam int DEF_TARGET = 4096;
  localparam int DEF_TOL    = 512;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lock_hysteresis_fsm.sv
// ---------------------------------------------------------------------------
// lock_hysteresis_fsm: good/bad window counting with SEARCH/LOCKED hysteresis
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lock_hysteresis_fsm
  import agc_lock_detect_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic window_done,
  input  logic window_good,
  input  logic clear,
  output logic lock
);

  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GOOD_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] BAD_LAST  = CW'(UNLOCK_CNT - 1);

  logic [0:0]    state;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] bad_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (clear) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (window_done) begin
      if (state == ST_SEARCH) begin
        if (!window_good) begin
          good_cnt <= '0;
        end else if (good_cnt >= GOOD_LAST) begin
          // Threshold reached: counters restart so they never pass it.
          state    <= ST_LOCKED;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end else begin
          good_cnt <= good_cnt + CW'(1);
        end
      end else begin
        if (window_good) begin
          bad_cnt <= '0;
        end else if (bad_cnt >= BAD_LAST) begin
          state    <= ST_SEARCH;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end else begin
          bad_cnt <= bad_cnt + CW'(1);
        end
      end
    end
  end

  assign lock = (state == ST_LOCKED);

endmodule

`default_nettype wire

// File: rtl/agc_lock_detect.sv
// ---------------------------------------------------------------------------
// agc_lock_detect: windowed mean of I/Q power compared against a target
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module agc_lock_detect
  import agc_lock_detect_pkg::*;
#(
  parameter int LOG2_WIN   = 4,
  parameter int TARGET     = DEF_TARGET,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] real_i,
  input  logic signed [SAMPLE_W-1:0] imag_i,
  input  logic                       valid_i,
  input  logic                       clear_i,
  output logic [15:0]                power_o,
  output logic                       power_valid_o,
  output logic                       lock_o
);

  localparam int SUM_W = ABS2_W + LOG2_WIN;

  logic signed [2*SAMPLE_W-1:0] re_sq;
  logic signed [2*SAMPLE_W-1:0] im_sq;
  logic [ABS2_W-1:0]            abs2_next;
  logic [ABS2_W-1:0]            abs2;
  logic                         s1_valid;
  logic [SUM_W-1:0]             sum;
  logic [SUM_W-1:0]             sum_next;
  logic [ABS2_W-1:0]            mean;
  logic signed [17:0]           diff;
  logic [17:0]                  mag;
  logic                         win_last;
  logic                         window_done;
  logic                         window_good;

  // Squares are never negative, so zero-extension of the bit patterns is exact.
  assign re_sq     = real_i * real_i;
  assign im_sq     = imag_i * imag_i;
  assign abs2_next = {1'b0, re_sq} + {1'b0, im_sq};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs2     <= '0;
      s1_valid <= 1'b0;
    end else begin
      abs2     <= abs2_next;
      s1_valid <= valid_i & ~clear_i;
    end
  end

  generate
    if (LOG2_WIN == 0) begin : g_single
      assign win_last = 1'b1;
    end else begin : g_count
      logic [LOG2_WIN-1:0] cnt;

      // Natural wrap brings the counter back to 0 on the window's last sample.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clear_i) begin
          cnt <= '0;
        end else if (s1_valid) begin
          cnt <= cnt + LOG2_WIN'(1);
        end
      end

      assign win_last = &cnt;
    end
  endgenerate

  assign sum_next    = sum + SUM_W'(abs2);
  assign mean        = sum_next[LOG2_WIN +: ABS2_W];
  assign diff        = $signed({1'b0, mean}) - $signed(18'(TARGET));
  assign mag         = diff[17] ? $unsigned(-diff) : $unsigned(diff);
  assign window_good = (mag <= 18'(TOL));
  assign window_done = s1_valid & win_last & ~clear_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum           <= '0;
      power_o       <= '0;
      power_valid_o <= 1'b0;
    end else begin
      power_valid_o <= 1'b0;
      if (clear_i) begin
        sum <= '0;
      end else if (s1_valid) begin
        if (win_last) begin
          sum           <= '0;
          power_o       <= mean[16] ? 16'hFFFF : mean[15:0];
          power_valid_o <= 1'b1;
        end else begin
          sum <= sum_next;
        end
      end
    end
  end

  lock_hysteresis_fsm #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .window_done (window_done),
    .window_good (window_good),
    .clear       (clear_i),
    .lock        (lock_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_agc_lock_detect.sv
// ---------------------------------------------------------------------------
// tb_agc_lock_detect: directed self-checking bench for agc_lock_detect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_agc_lock_detect;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] real_i;
  logic signed [7:0] imag_i;
  logic              valid_i;
  logic              clear_i;
  logic [15:0]       power;
  logic              pv;
  logic              lock;
  logic [15:0]       power0;
  logic              pv0;
  logic              lock0;

  int checks = 0;
  int passes = 0;

  int          np = 0;
  logic [15:0] power_hist [0:127];
  logic        lock_hist  [0:127];

  always #5 clk = ~clk;

  agc_lock_detect dut (
    .clk           (clk),
    .rst           (rst),
    .real_i        (real_i),
    .imag_i        (imag_i),
    .valid_i       (valid_i),
    .clear_i       (clear_i),
    .power_o       (power),
    .power_valid_o (pv),
    .lock_o        (lock)
  );

  agc_lock_detect #(.LOG2_WIN(0)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .real_i        (real_i),
    .imag_i        (imag_i),
    .valid_i       (valid_i),
    .clear_i       (clear_i),
    .power_o       (power0),
    .power_valid_o (pv0),
    .lock_o        (lock0)
  );

  always @(negedge clk) begin
    if (pv === 1'b1) begin
      if (np < 128) begin
        power_hist[np] <= power;
        lock_hist[np]  <= lock;
      end
      np <= np + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    tick();
    tick();
  endtask

  task automatic drive(input int re, input int im, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      real_i  = 8'(re);
      imag_i  = 8'(im);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; clear_i = 1'b0; real_i = '0; imag_i = '0;
    tick(); tick();
    checks++; if (power !== 16'd0) $display("FAIL reset_power: got %0d want 0", power); else passes++;
    checks++; if (pv !== 1'b0) $display("FAIL reset_pv: got %b want 0", pv); else passes++;
    checks++; if (lock !== 1'b0) $display("FAIL reset_lock: got %b want 0", lock); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    drive(64, 0, 15, 0);
    real_i = 8'sd64; imag_i = 8'sd0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    checks++; if (pv !== 1'b0) $display("FAIL lat_early: got pv=%b want 0 at t+1", pv); else passes++;
    tick();
    checks++; if (pv !== 1'b1) $display("FAIL lat_pulse: got pv=%b want 1 at t+2", pv); else passes++;
    checks++; if (power !== 16'd4096) $display("FAIL lat_power: got %0d want 4096", power); else passes++;
    checks++; if (lock !== 1'b0) $display("FAIL lat_lock: got %b want 0", lock); else passes++;
    tick();
    checks++; if (pv !== 1'b0) $display("FAIL lat_one_cycle: got pv=%b want 0", pv); else passes++;
    checks++; if (power !== 16'd4096) $display("FAIL lat_hold: got %0d want 4096", power); else passes++;
  endtask

  task automatic test_lock_acquire();
    int b;
    b = np;
    drive(64, 0, 48, 0);
    flush();
    checks++; if (np - b !== 3) $display("FAIL acq_pulses: got %0d want 3", np - b); else passes++;
    checks++; if (lock_hist[b+1] !== 1'b0) $display("FAIL acq_lock_3rd: got %b want 0", lock_hist[b+1]); else passes++;
    checks++; if (lock_hist[b+2] !== 1'b1) $display("FAIL acq_lock_4th: got %b want 1", lock_hist[b+2]); else passes++;
  endtask

  task automatic test_unlock();
    int b;
    b = np;
    drive(0, 0, 32, 0);
    flush();
    checks++; if (np - b !== 2) $display("FAIL unl_pulses: got %0d want 2", np - b); else passes++;
    checks++; if (power_hist[b+1] !== 16'd0) $display("FAIL unl_power: got %0d want 0", power_hist[b+1]); else passes++;
    checks++; if (lock_hist[b] !== 1'b1) $display("FAIL unl_first_bad: got %b want 1", lock_hist[b]); else passes++;
    checks++; if (lock_hist[b+1] !== 1'b0) $display("FAIL unl_second_bad: got %b want 0", lock_hist[b+1]); else passes++;
  endtask

  task automatic test_tolerance();
    int b;
    do_clear();
    b = np;
    drive(48, 48, 16, 0);
    drive(67, 0, 32, 0);
    drive(48, 48, 15, 0);
    drive(68, 0, 1, 0);
    drive(67, 0, 48, 0);
    flush();
    checks++; if (np - b !== 7) $display("FAIL tol_pulses: got %0d want 7", np - b); else passes++;
    checks++; if (power_hist[b] !== 16'd4608) $display("FAIL tol_edge_good: got %0d want 4608", power_hist[b]); else passes++;
    checks++; if (power_hist[b+1] !== 16'd4489) $display("FAIL tol_67: got %0d want 4489", power_hist[b+1]); else passes++;
    checks++; if (power_hist[b+3] !== 16'd4609) $display("FAIL tol_edge_bad: got %0d want 4609", power_hist[b+3]); else passes++;
    checks++; if (lock_hist[b+6] !== 1'b0) $display("FAIL tol_cnt_cleared: got %b want 0", lock_hist[b+6]); else passes++;
    drive(67, 0, 16, 0);
    flush();
    checks++; if (lock_hist[b+7] !== 1'b1) $display("FAIL tol_relock: got %b want 1", lock_hist[b+7]); else passes++;
  endtask

  task automatic test_alternate();
    int b;
    int locks;
    do_clear();
    b = np;
    for (int k = 0; k < 3; k++) begin
      drive(67, 0, 16, 0);
      drive(68, 0, 16, 0);
    end
    flush();
    locks = 0;
    for (int k = 0; k < 6; k++) locks += int'(lock_hist[b+k]);
    checks++; if (np - b !== 6) $display("FAIL alt_pulses: got %0d want 6", np - b); else passes++;
    checks++; if (power_hist[b+1] !== 16'd4624) $display("FAIL alt_68: got %0d want 4624", power_hist[b+1]); else passes++;
    checks++; if (locks !== 0) $display("FAIL alt_nolock: got %0d locked windows want 0", locks); else passes++;
  endtask

  task automatic test_saturation();
    int b;
    do_clear();
    b = np;
    drive(67, 0, 48, 0);
    real_i = -8'sd128; imag_i = -8'sd128; valid_i = 1'b1;
    tick(); tick();
    checks++; if (pv0 !== 1'b1) $display("FAIL sat_w0_pulse: got %b want 1", pv0); else passes++;
    checks++; if (power0 !== 16'd32768) $display("FAIL sat_w0_power: got %0d want 32768", power0); else passes++;
    valid_i = 1'b0;
    drive(-128, -128, 14, 0);
    flush();
    checks++; if (lock0 !== 1'b0) $display("FAIL sat_w0_lock: got %b want 0", lock0); else passes++;
    checks++; if (power_hist[b+3] !== 16'd32768) $display("FAIL sat_power: got %0d want 32768", power_hist[b+3]); else passes++;
    drive(67, 0, 16, 0);
    flush();
    checks++; if (lock_hist[b+4] !== 1'b0) $display("FAIL sat_bad: got %b want 0", lock_hist[b+4]); else passes++;
  endtask

  task automatic test_sparse();
    int b;
    do_clear();
    b = np;
    drive(64, 0, 15, 2);
    flush();
    checks++; if (np - b !== 0) $display("FAIL sparse_early: got %0d pulses want 0", np - b); else passes++;
    drive(64, 0, 1, 2);
    checks++; if (np - b !== 1) $display("FAIL sparse_pulse: got %0d pulses want 1", np - b); else passes++;
    checks++; if (power !== 16'd4096) $display("FAIL sparse_power: got %0d want 4096", power); else passes++;
  endtask

  task automatic test_clear();
    int b;
    do_clear();
    drive(64, 0, 64, 0);
    flush();
    checks++; if (lock !== 1'b1) $display("FAIL clr_prelock: got %b want 1", lock); else passes++;
    drive(68, 0, 8, 0);
    do_clear();
    checks++; if (lock !== 1'b0) $display("FAIL clr_lock: got %b want 0", lock); else passes++;
    checks++; if (power !== 16'd4096) $display("FAIL clr_hold: got %0d want 4096", power); else passes++;
    b = np;
    drive(64, 0, 15, 0);
    real_i = 8'sd64; imag_i = 8'sd0; valid_i = 1'b1; clear_i = 1'b1;
    tick();
    valid_i = 1'b0; clear_i = 1'b0;
    flush();
    checks++; if (np - b !== 0) $display("FAIL clr_nopulse: got %0d pulses want 0", np - b); else passes++;
    drive(67, 0, 16, 0);
    flush();
    checks++; if (np - b !== 1) $display("FAIL clr_fresh: got %0d pulses want 1", np - b); else passes++;
    checks++; if (power_hist[b] !== 16'd4489) $display("FAIL clr_fresh_power: got %0d want 4489", power_hist[b]); else passes++;
  endtask

  task automatic test_async_reset();
    int b;
    do_clear();
    drive(64, 0, 64, 0);
    flush();
    checks++; if (lock !== 1'b1) $display("FAIL ares_prelock: got %b want 1", lock); else passes++;
    drive(64, 0, 8, 0);
    #2 rst = 1'b1;
    #1;
    checks++; if (power !== 16'd0) $display("FAIL ares_power: got %0d want 0", power); else passes++;
    checks++; if (pv !== 1'b0) $display("FAIL ares_pv: got %b want 0", pv); else passes++;
    checks++; if (lock !== 1'b0) $display("FAIL ares_lock: got %b want 0", lock); else passes++;
    #2 rst = 1'b0;
    b = np;
    drive(64, 0, 8, 0);
    flush();
    checks++; if (np - b !== 0) $display("FAIL ares_discard: got %0d pulses want 0", np - b); else passes++;
    drive(64, 0, 40, 0);
    flush();
    checks++; if (lock_hist[b+2] !== 1'b0) $display("FAIL ares_3rd: got %b want 0", lock_hist[b+2]); else passes++;
    drive(64, 0, 16, 0);
    flush();
    checks++; if (np - b !== 4) $display("FAIL ares_pulses: got %0d want 4", np - b); else passes++;
    checks++; if (lock_hist[b+3] !== 1'b1) $display("FAIL ares_relock: got %b want 1", lock_hist[b+3]); else passes++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_lock_acquire();
    test_unlock();
    test_tolerance();
    test_alternate();
    test_saturation();
    test_sparse();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
